// File: rtl/pwm_generator_multi_if.sv
// Button/control inputs and PWM outputs of the multi-channel PWM generator.
// slave is the generator side, master is the board/driver side.
interface pwm_generator_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       increase_duty;
  logic [NUM_CH-1:0]       decrease_duty;
  logic                    enable;
  logic                    center_mode;
  logic [NUM_CH-1:0]       PWM_OUT;
  logic                    period_start;
  logic [NUM_CH*CNT_W-1:0] duty_out;

  modport master (
    output increase_duty, decrease_duty, enable, center_mode,
    input  PWM_OUT, period_start, duty_out
  );
  modport slave (
    input  increase_duty, decrease_duty, enable, center_mode,
    output PWM_OUT, period_start, duty_out
  );
endinterface

// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM: one shared up / up-down period counter, per-channel
// debounced duty buttons, shadow-loaded duty compare with registered outputs.

module pwm_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  logic [1:0]      sync;
  logic [DB_W-1:0] db_cnt;

  // press fires once, on the cycle db_cnt steps to DB_MAX; the counter then holds
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= sync[1] && (db_cnt == DB_MAX - 1'b1);
      if (!sync[1])              db_cnt <= '0;
      else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 1'b1;
    end
  end
endmodule

module pwm_channel #(
  parameter int CNT_W           = 8,
  parameter int PERIOD          = 10,
  parameter int STEP            = 1,
  parameter int DUTY_INIT       = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_btn,
  input  logic             dec_btn,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic [CNT_W-1:0] duty
);
  localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] INIT   = CNT_W'(DUTY_INIT);

  logic             inc, dec;
  logic [CNT_W:0]   sum, diff;
  logic [CNT_W-1:0] duty_nxt, shadow, shadow_eff;

  pwm_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (.clk, .rst, .btn(inc_btn), .press(inc));
  pwm_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (.clk, .rst, .btn(dec_btn), .press(dec));

  // one extra bit: sum catches overflow past PERIOD, diff's MSB is the borrow
  always_comb begin
    sum      = {1'b0, duty} + STEP_X;
    diff     = {1'b0, duty} - STEP_X;
    duty_nxt = duty;
    if (inc && !dec)      duty_nxt = (sum > PER_X) ? PER_X[CNT_W-1:0] : sum[CNT_W-1:0];
    else if (dec && !inc) duty_nxt = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
  end

  // at the boundary the new period compares against the freshly loaded value
  assign shadow_eff = load ? duty : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty   <= INIT;
      shadow <= INIT;
      pwm    <= 1'b0;
    end else begin
      duty <= duty_nxt;
      if (load) shadow <= duty;
      pwm <= run && (cnt < shadow_eff);
    end
  end
endmodule

module pwm_generator_multi #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 8,
  parameter int PERIOD          = 10,
  parameter int STEP            = 1,
  parameter int DUTY_INIT       = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  pwm_generator_multi_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;   // 0 = counting up
  logic             mode, mode_eff;
  logic             boundary;

  logic [NUM_CH-1:0]            pwm;
  logic [NUM_CH-1:0][CNT_W-1:0] duty;

  assign boundary = bus.enable && (cnt == '0) && !dir;
  assign mode_eff = boundary ? bus.center_mode : mode;

  // center mode dwells one extra cycle at each end so the period is 2*PERIOD
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b0;
    if (bus.enable) begin
      if (!mode_eff) begin
        cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end else if (!dir) begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        dir_nxt = (cnt == CNT_MAX);
      end else begin
        cnt_nxt = (cnt == '0) ? cnt : cnt - 1'b1;
        dir_nxt = (cnt != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      dir              <= 1'b0;
      mode             <= 1'b0;
      bus.period_start <= 1'b0;
    end else begin
      cnt              <= cnt_nxt;
      dir              <= dir_nxt;
      if (boundary) mode <= bus.center_mode;
      bus.period_start <= boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP),
      .DUTY_INIT(DUTY_INIT), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk, .rst,
      .inc_btn (bus.increase_duty[i]),
      .dec_btn (bus.decrease_duty[i]),
      .load    (boundary),
      .run     (bus.enable),
      .cnt     (cnt),
      .pwm     (pwm[i]),
      .duty    (duty[i])
    );
  end

  assign bus.PWM_OUT  = pwm;
  assign bus.duty_out = duty;
endmodule

// File: doc/pwm_generator_multi.md
Name: pwm_generator_multi

Overview:
- Multi-channel successor to the single-channel PWM_generator; one shared period counter drives NUM_CH independent PWM outputs.
- Each channel has its own increase/decrease push-button inputs, with synchronisation, debounce and one-step-per-press edge detection.
- Duty values saturate at 0% and 100% and are shadow-loaded at period boundaries so outputs never glitch.
- Supports edge-aligned and center-aligned modes. Sits between the board button/GPIO layer and the motor/LED drive pins.

Parameters:
- NUM_CH, 4: number of independent PWM channels.
- CNT_W, 8: width of the counter and duty registers; must satisfy PERIOD < 2^CNT_W.
- PERIOD, 10: counts per PWM period (edge mode); duty resolution is 1/PERIOD.
- STEP, 1: duty change per accepted press, in counts.
- DUTY_INIT, 5: duty loaded on reset; must be <= PERIOD.
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high samples required to accept a press; must be >= 1.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  synchronous, active-high reset.
- increase_duty  input  NUM_CH  per-channel asynchronous button; a press raises duty by STEP.
- decrease_duty  input  NUM_CH  per-channel asynchronous button; a press lowers duty by STEP.
- enable  input  1  1 = run; 0 = counter held, outputs low.
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary.
- PWM_OUT  output  NUM_CH  PWM outputs, registered.
- period_start  output  1  one-cycle pulse on the first cycle of each period.
- duty_out  output  NUM_CH*CNT_W  active (working) duty register per channel; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - Counter = 0, direction = up, mode latch = 0.
  - All duty and shadow registers = DUTY_INIT.
  - Synchronisers, debounce counters and press flags cleared.
  - PWM_OUT = 0, period_start = 0.
  - Reset mid-operation discards any in-flight press and restarts the period.
- Input conditioning, per button:
  - 2-flop synchroniser feeds a debounce counter that increments while the synced level is 1 and clears to 0 when it is 0.
  - A press is accepted on the single cycle the counter reaches DEBOUNCE_CYCLES. The counter then holds, so a held button yields exactly one step.
  - Button asserted before edge k (sampled at edge k): duty_out updates at edge k+2+DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES synced cycles are ignored.
- Duty update, per channel, on an accepted press:
  - Increase only: duty = min(duty+STEP, PERIOD).
  - Decrease only: duty = max(duty-STEP, 0), with no unsigned wrap.
  - Both accepted in the same cycle: no change.
  - Arithmetic is done in CNT_W+1 bits before clamping.
- Shadow: the shadow duty copies the working duty, and the mode latch copies center_mode, on the cycle the counter wraps to the start of a new period. Comparisons use shadow values only.
- Edge mode (mode latch = 0):
  - Counter runs 0..PERIOD-1, then wraps to 0.
  - PWM_OUT[i] = (cnt < shadow[i]), registered with 1-cycle latency.
- Center mode (mode latch = 1):
  - Counter runs up 0..PERIOD-1, then down PERIOD-1..0; each endpoint is held twice. The period is 2*PERIOD cycles.
  - PWM_OUT[i] = (cnt < shadow[i]), registered. The high time is 2*shadow[i] cycles, contiguous across the count-0 turnaround, so the pulse is centred on the period boundary.
- Duty of 0 gives constant low; duty of PERIOD gives constant high with no glitch at the wrap.
- period_start is 1 for the cycle the counter is 0 with direction up; this is also when shadows load.
- enable=0: counter and direction held at 0/up, PWM_OUT forced 0, period_start 0. Button conditioning and duty updates continue. On re-enable, a new period starts and shadows load.
- Mode change mid-period takes effect only at the next period boundary.

Test Plan:
- Reset, defaults, enable=1, edge mode -> duty_out all 5. Each PWM_OUT is high exactly 5 of every 10 cycles; period_start pulses every 10 cycles.
- Three clean 100-cycle presses on increase_duty[0] -> duty_out[0] = 8, PWM_OUT[0] high 8/10 from the period after each update. Channels 1-3 are unchanged at 5.
- increase_duty[1] held for 200 cycles -> exactly one step (6). A 3-cycle glitch on decrease_duty[1] -> no change.
- Six presses increase on ch2 from 5 -> saturates at 10, PWM_OUT[2] constant high. Then eleven decrease presses -> 0, constant low, no wrap to 255.
- increase_duty[3] and decrease_duty[3] asserted on the same cycle for 100 cycles -> duty stays 5.
- center_mode=1 toggled mid-period with ch0 duty 4 -> the current period finishes in edge mode. Afterwards the period is 20 cycles and PWM_OUT[0] is high 8 consecutive cycles spanning the count-0 turnaround. Asserting rst mid-period -> all outputs 0 on the next cycle and duty returns to 5.
